spi_slave_if: RTL

- SPI slave front-end that drives the single-port RAM's command/data interface.
- Deserialises MOSI frames of ADDR_SIZE+2 bits (2-bit opcode + ADDR_SIZE payload) into rx_data/rx_valid.
- On a read-data command, waits for the RAM's tx_valid/tx_data and serialises the returned byte on MISO.
- Sits between the SPI pads and the RAM; the SPI serial clock is used directly as clk.

---
 rtl/spi_slave_if.sv | 138 +++++++++++++
 1 files changed

// File: rtl/spi_slave_if.sv
// SPI slave front-end: deserialises {opcode, payload} frames for the RAM and shifts read data out on MISO.
// Optional abort reporting output frame_err is enabled by defining SPI_FRAME_ERR_EN.
module spi_slave_if #(
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 SS_n,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic [ADDR_SIZE+1:0] rx_data,
  output logic                 rx_valid,
  input  logic [ADDR_SIZE-1:0] tx_data,
  input  logic                 tx_valid
`ifdef SPI_FRAME_ERR_EN
  ,
  output logic                 frame_err
`endif
);
  localparam int FW = ADDR_SIZE + 2;
  localparam int CW = $clog2(FW + 1);
  localparam int TW = $clog2(ADDR_SIZE + 1);

  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;
  state_t state_reg, state_next;

  logic [CW-1:0]        bit_cnt_reg;
  logic [FW-2:0]        rx_shift_reg;
  logic [FW-1:0]        rx_data_reg;
  logic                 rx_valid_reg;
  logic                 rd_addr_seen_reg;
  logic [ADDR_SIZE-1:0] tx_shift_reg;
  logic [TW-1:0]        tx_cnt_reg;
  logic                 tx_busy_reg;
  logic                 tx_done_reg;
  logic                 miso_reg;

  logic          in_frame;
  logic          abort;
  logic          frame_done;
  logic          frame_last;
  logic          tx_start;
  logic [FW-1:0] frame_word;

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    in_frame   = (state_reg == WRITE) || (state_reg == READ_ADD) || (state_reg == READ_DATA);
    abort      = (state_reg != IDLE) && SS_n;
    frame_done = (bit_cnt_reg == CW'(FW));
    frame_last = in_frame && !SS_n && (bit_cnt_reg == CW'(FW - 1));
    frame_word = {rx_shift_reg, MOSI};
    // Read data is accepted only once the frame has been delivered, and only once per select.
    tx_start   = (state_reg == READ_DATA) && !SS_n && frame_done &&
                 !tx_busy_reg && !tx_done_reg && tx_valid;
    case (state_reg)
      IDLE:    if (!SS_n) state_next = CHK_CMD;
      CHK_CMD: begin
        if (SS_n)                  state_next = IDLE;
        else if (!MOSI)            state_next = WRITE;
        else if (rd_addr_seen_reg) state_next = READ_DATA;
        else                       state_next = READ_ADD;
      end
      default: if (SS_n) state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt_reg      <= '0;
      rx_shift_reg     <= '0;
      rx_data_reg      <= '0;
      rx_valid_reg     <= 1'b0;
      rd_addr_seen_reg <= 1'b0;
      tx_shift_reg     <= '0;
      tx_cnt_reg       <= '0;
      tx_busy_reg      <= 1'b0;
      tx_done_reg      <= 1'b0;
      miso_reg         <= 1'b0;
    end else begin
      rx_valid_reg <= 1'b0;
      if (abort || state_reg == IDLE) begin
        bit_cnt_reg  <= '0;
        rx_shift_reg <= '0;
        tx_shift_reg <= '0;
        tx_cnt_reg   <= '0;
        tx_busy_reg  <= 1'b0;
        tx_done_reg  <= 1'b0;
        miso_reg     <= 1'b0;
      end else begin
        if ((state_reg == CHK_CMD || in_frame) && !frame_done) begin
          bit_cnt_reg  <= bit_cnt_reg + 1'b1;
          rx_shift_reg <= {rx_shift_reg[FW-3:0], MOSI};
        end
        if (frame_last) begin
          rx_data_reg  <= frame_word;
          rx_valid_reg <= 1'b1;
          if (frame_word[FW-1:FW-2] == 2'b10)      rd_addr_seen_reg <= 1'b1;
          else if (frame_word[FW-1:FW-2] == 2'b11) rd_addr_seen_reg <= 1'b0;
        end
        if (tx_start) begin
          miso_reg     <= tx_data[ADDR_SIZE-1];
          tx_shift_reg <= tx_data << 1;
          tx_cnt_reg   <= TW'(ADDR_SIZE - 1);
          tx_busy_reg  <= 1'b1;
        end else if (tx_busy_reg) begin
          if (tx_cnt_reg == '0) begin
            miso_reg    <= 1'b0;
            tx_busy_reg <= 1'b0;
            tx_done_reg <= 1'b1;
          end else begin
            miso_reg     <= tx_shift_reg[ADDR_SIZE-1];
            tx_shift_reg <= tx_shift_reg << 1;
            tx_cnt_reg   <= tx_cnt_reg - 1'b1;
          end
        end
      end
    end
  end

`ifdef SPI_FRAME_ERR_EN
  logic err_reg;
  // An abort counts as an error only if it cuts a frame or a read byte short.
  always_ff @(posedge clk) begin
    if (!rst_n) err_reg <= 1'b0;
    else        err_reg <= abort && ((bit_cnt_reg != '0 && !frame_done) || tx_busy_reg);
  end
  assign frame_err = err_reg;
`endif

  assign MISO     = miso_reg;
  assign rx_data  = rx_data_reg;
  assign rx_valid = rx_valid_reg;
endmodule
